// File: rtl/rvc_asap_5pl_cr_arb.sv
`default_nettype none
// ============================================================================
// Module   : rvc_asap_5pl_cr_arb
// Purpose  : Two-requester round-robin arbiter sharing the single CR port
//            between the core MEM stage (Rq0) and a debug/host master (Rq1).
//            Supports a lock for atomic read-modify-write sequences and
//            routes the 1-cycle-latency load data back to its requester.
// Options  : RVC_CR_ARB_LOCK_TIMEOUT_EN - forced lock release after
//            LOCK_TIMEOUT idle cycles of the lock owner.
// Revision : 1.0 - initial release
// ============================================================================
module rvc_asap_5pl_cr_arb #(
  parameter int LOCK_TIMEOUT = 16
) (
  input  logic        Clock,
  input  logic        Rst,
  input  logic        Rq0Valid,
  input  logic        Rq0WrEn,
  input  logic        Rq0Lock,
  input  logic [31:0] Rq0Addr,
  input  logic [31:0] Rq0WrData,
  input  logic        Rq1Valid,
  input  logic        Rq1WrEn,
  input  logic        Rq1Lock,
  input  logic [31:0] Rq1Addr,
  input  logic [31:0] Rq1WrData,
  output logic        Rq0Ready,
  output logic        Rq1Ready,
  output logic        Rq0RspValid,
  output logic        Rq1RspValid,
  output logic [31:0] RspData,
  output logic [31:0] AluOut,
  output logic [31:0] RegRdData2,
  output logic        CtrlCRMemWrEn,
  output logic        SelCRMemWb,
  input  logic [31:0] CRMemRdDataQ104H,
  output logic        LockTimeout
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    LOCK0 = 2'd1,
    LOCK1 = 2'd2
  } state_t;

  state_t      r_state;
  state_t      w_state_nxt;
  logic        r_last_gnt;   // 0: Rq0 won last, 1: Rq1 won last
  logic        w_last_nxt;
  logic [1:0]  r_rd_pend;    // one-hot owner of the load in flight
  logic        w_gnt0;
  logic        w_gnt1;
  logic        w_timeout;

  // Grant decision: combinational in the request cycle, suppressed in reset
  always_comb begin
    w_gnt0 = 1'b0;
    w_gnt1 = 1'b0;
    if (!Rst) begin
      case (r_state)
        IDLE: begin
          if (Rq0Valid && Rq1Valid) begin
            w_gnt0 = r_last_gnt;
            w_gnt1 = !r_last_gnt;
          end else begin
            w_gnt0 = Rq0Valid;
            w_gnt1 = Rq1Valid;
          end
        end
        LOCK0:   w_gnt0 = Rq0Valid;
        LOCK1:   w_gnt1 = Rq1Valid;
        default: ;
      endcase
    end
  end

  // Next state and round-robin pointer
  always_comb begin
    w_state_nxt = r_state;
    w_last_nxt  = r_last_gnt;
    if (w_gnt0) begin
      w_last_nxt  = 1'b0;
      w_state_nxt = Rq0Lock ? LOCK0 : IDLE;
    end else if (w_gnt1) begin
      w_last_nxt  = 1'b1;
      w_state_nxt = Rq1Lock ? LOCK1 : IDLE;
    end else if (w_timeout || (r_state != IDLE && r_state != LOCK0 && r_state != LOCK1)) begin
      w_state_nxt = IDLE;
    end
  end

  // State, pointer and pending-load registers
  always_ff @(posedge Clock) begin
    if (Rst) begin
      r_state    <= IDLE;
      r_last_gnt <= 1'b1;
      r_rd_pend  <= 2'b00;
    end else begin
      r_state    <= w_state_nxt;
      r_last_gnt <= w_last_nxt;
      r_rd_pend  <= {w_gnt1 && !Rq1WrEn, w_gnt0 && !Rq0WrEn};
    end
  end

`ifdef RVC_CR_ARB_LOCK_TIMEOUT_EN
  localparam int c_cnt_w = $clog2(LOCK_TIMEOUT + 1);

  logic [c_cnt_w-1:0] r_lock_cnt;
  logic               w_lock_idle;

  // The lock owner is idle in any lock cycle where it is not granted
  assign w_lock_idle = !Rst && ((r_state == LOCK0 && !w_gnt0) ||
                                (r_state == LOCK1 && !w_gnt1));
  // Fire on the idle cycle that would bring the count up to LOCK_TIMEOUT
  assign w_timeout   = w_lock_idle && (r_lock_cnt == c_cnt_w'(LOCK_TIMEOUT - 1));

  // Idle-cycle counter of the current lock owner
  always_ff @(posedge Clock) begin
    if (Rst || !w_lock_idle || w_timeout) begin
      r_lock_cnt <= '0;
    end else begin
      r_lock_cnt <= r_lock_cnt + 1'b1;
    end
  end
`else
  // Locks are held indefinitely; the parameter has no effect in this build
  assign w_timeout = (LOCK_TIMEOUT < 0);
`endif

  assign LockTimeout   = w_timeout;

  assign Rq0Ready      = w_gnt0;
  assign Rq1Ready      = w_gnt1;

  assign AluOut        = w_gnt0 ? Rq0Addr   : (w_gnt1 ? Rq1Addr   : 32'h0);
  assign RegRdData2    = w_gnt0 ? Rq0WrData : (w_gnt1 ? Rq1WrData : 32'h0);
  assign CtrlCRMemWrEn = (w_gnt0 && Rq0WrEn)  || (w_gnt1 && Rq1WrEn);
  assign SelCRMemWb    = (w_gnt0 && !Rq0WrEn) || (w_gnt1 && !Rq1WrEn);

  // A response still in flight when reset arrives is discarded
  assign Rq0RspValid   = !Rst && r_rd_pend[0];
  assign Rq1RspValid   = !Rst && r_rd_pend[1];
  assign RspData       = (!Rst && (r_rd_pend != 2'b00)) ? CRMemRdDataQ104H : 32'h0;

endmodule
`default_nettype wire
